// File: rtl/lightgun_aim_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lightgun_aim_conditioner: stick/button front end for lightgun emulation  |
// | Rev 1.0 - frame-locked aim (absolute/relative), debounce, autofire       |
// +--------------------------------------------------------------------------+
module lightgun_aim_conditioner #(
  parameter logic [7:0]  DEADZONE        = 8'd12,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1024,
  parameter logic [3:0]  AF_PERIOD       = 4'd3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       VDE,
  input  logic       MODE,
  input  logic [2:0] SPEED,
  input  logic       AUTOFIRE,
  input  logic       RECENTER,
  input  logic [7:0] STICK_X,
  input  logic [7:0] STICK_Y,
  input  logic       TRIG_IN,
  input  logic       CURSOR_IN,
  input  logic       TURBO_IN,
  input  logic       PAUSE_IN,
  output logic [7:0] JOY_X,
  output logic [7:0] JOY_Y,
  output logic       F,
  output logic       C,
  output logic       T,
  output logic       P,
  output logic       FRAME_TICK
);

  logic        old_vde_q, old_recenter_q, old_mode_q, frame_tick_q;
  logic [7:0]  joy_x_q, joy_x_d, joy_y_q, joy_y_d;
  logic [15:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [3:0]  db_q, db_d;
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic        f_q, f_d;
  logic [3:0]  af_q, af_d;

  logic       tick, recenter_rise;
  logic [3:0] raw;

  assign tick          = VDE & ~old_vde_q;
  assign recenter_rise = RECENTER & ~old_recenter_q;
  assign raw           = {PAUSE_IN, TURBO_IN, CURSOR_IN, TRIG_IN};

  function automatic logic signed [8:0] deadzone(input logic [7:0] stick);
    logic signed [8:0] d;
    logic signed [8:0] dz;
    d  = $signed({1'b0, stick}) - 9'sd128;
    dz = $signed({1'b0, DEADZONE});
    if (d > dz)       deadzone = d - dz;
    else if (d < -dz) deadzone = d + dz;
    else              deadzone = 9'sd0;
  endfunction

  // Returns {joy_next, acc_next} for one axis on a frame tick.
  function automatic logic [23:0] aim_next(input logic mode, input logic [2:0] speed,
                                           input logic [7:0] stick, input logic [15:0] acc,
                                           input logic [7:0] joy);
    logic signed [8:0]  e;
    logic signed [17:0] s;
    logic signed [17:0] sum;
    logic [15:0]        a;
    logic [7:0]         j;
    e   = deadzone(stick);
    a   = acc;
    j   = joy;
    s   = 18'sd0;
    sum = 18'sd0;
    if (!mode) begin
      j = (e == 9'sd0) ? 8'd128 : stick;
      a = {j, 8'h00};
    end else if (e != 9'sd0) begin
      s   = $signed({{9{e[8]}}, e}) <<< speed;
      sum = $signed({2'b00, acc}) + s;
      if (sum[17])      a = 16'h0000;
      else if (sum[16]) a = 16'hFFFF;
      else              a = sum[15:0];
      j = a[15:8];
    end
    return {j, a};
  endfunction

  // Recentre beats a mode change, which beats a frame update.
  always_comb begin
    joy_x_d = joy_x_q;
    joy_y_d = joy_y_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (recenter_rise) begin
      joy_x_d = 8'd128;
      joy_y_d = 8'd128;
      acc_x_d = 16'h8000;
      acc_y_d = 16'h8000;
    end else if (MODE != old_mode_q) begin
      acc_x_d = {joy_x_q, 8'h00};
      acc_y_d = {joy_y_q, 8'h00};
    end else if (tick) begin
      {joy_x_d, acc_x_d} = aim_next(MODE, SPEED, STICK_X, acc_x_q, joy_x_q);
      {joy_y_d, acc_y_d} = aim_next(MODE, SPEED, STICK_Y, acc_y_q, joy_y_q);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = cnt_q[i];
      if (raw[i] == db_q[i]) begin
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] >= DEBOUNCE_CYCLES - 16'd1) begin
        db_d[i]  = raw[i];
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] != 16'hFFFF) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Trigger output follows the debounced level, or bursts on frame ticks.
  always_comb begin
    f_d  = f_q;
    af_d = af_q;
    if (!db_d[0]) begin
      f_d  = 1'b0;
      af_d = 4'd0;
    end else if (!AUTOFIRE || !db_q[0]) begin
      f_d  = 1'b1;
      af_d = 4'd0;
    end else if (tick) begin
      if (af_q == AF_PERIOD - 4'd1) begin
        f_d  = ~f_q;
        af_d = 4'd0;
      end else begin
        af_d = af_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      old_vde_q      <= 1'b0;
      old_recenter_q <= 1'b0;
      old_mode_q     <= 1'b0;
      frame_tick_q   <= 1'b0;
      joy_x_q        <= 8'd128;
      joy_y_q        <= 8'd128;
      acc_x_q        <= 16'h8000;
      acc_y_q        <= 16'h8000;
      db_q           <= 4'd0;
      f_q            <= 1'b0;
      af_q           <= 4'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 16'd0;
    end else begin
      old_vde_q      <= VDE;
      old_recenter_q <= RECENTER;
      old_mode_q     <= MODE;
      frame_tick_q   <= tick;
      joy_x_q        <= joy_x_d;
      joy_y_q        <= joy_y_d;
      acc_x_q        <= acc_x_d;
      acc_y_q        <= acc_y_d;
      db_q           <= db_d;
      f_q            <= f_d;
      af_q           <= af_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign JOY_X      = joy_x_q;
  assign JOY_Y      = joy_y_q;
  assign F          = f_q;
  assign C          = db_q[1];
  assign T          = db_q[2];
  assign P          = db_q[3];
  assign FRAME_TICK = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_lightgun_aim_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lightgun_aim_conditioner: scoreboard bench for the aim conditioner    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lightgun_aim_conditioner;
  localparam int N = 1024;

  logic       CLK = 1'b0;
  logic       RESET_N, VDE, MODE, AUTOFIRE, RECENTER;
  logic [2:0] SPEED;
  logic [7:0] STICK_X, STICK_Y;
  logic       TRIG_IN, CURSOR_IN, TURBO_IN, PAUSE_IN;
  logic [7:0] JOY_X, JOY_Y;
  logic       F, C, T, P, FRAME_TICK;

  lightgun_aim_conditioner dut (
    .CLK(CLK), .RESET_N(RESET_N), .VDE(VDE), .MODE(MODE), .SPEED(SPEED),
    .AUTOFIRE(AUTOFIRE), .RECENTER(RECENTER), .STICK_X(STICK_X), .STICK_Y(STICK_Y),
    .TRIG_IN(TRIG_IN), .CURSOR_IN(CURSOR_IN), .TURBO_IN(TURBO_IN), .PAUSE_IN(PAUSE_IN),
    .JOY_X(JOY_X), .JOY_Y(JOY_Y), .F(F), .C(C), .T(T), .P(P), .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [7:0] x; logic [7:0] y;} aim_t;
  typedef struct {logic v; int c;} fev_t;
  aim_t aim_q[$];
  fev_t fev_q[$];
  aim_t aim_e;
  fev_t fev_e;
  logic prev_f = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Aim scoreboard: each FRAME_TICK pulse must match the next queued frame.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && FRAME_TICK === 1'b1) begin
      if (aim_q.size() == 0) begin
        check("unexpected_frame_tick", 1, 0);
      end else begin
        aim_e = aim_q.pop_front();
        check("JOY_X", int'(JOY_X), int'(aim_e.x));
        check("JOY_Y", int'(JOY_Y), int'(aim_e.y));
      end
    end
  end

  // Trigger scoreboard: every change of F must match the next queued event.
  always @(negedge CLK) begin
    if (RESET_N !== 1'b1) begin
      prev_f = 1'b0;
    end else if (F !== prev_f) begin
      prev_f = F;
      if (fev_q.size() == 0) begin
        check("F_spurious_edge", int'(F), -1);
      end else begin
        fev_e = fev_q.pop_front();
        check("F_value", int'(F), int'(fev_e.v));
        check("F_cycle", cyc, fev_e.c);
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic frame(logic [7:0] ex, logic [7:0] ey);
    aim_q.push_back('{x: ex, y: ey});
    VDE = 1'b1;
    wait_cyc(3);
    VDE = 1'b0;
    wait_cyc(3);
  endtask

  task automatic push_f(logic v, int c);
    fev_q.push_back('{v, c});
  endtask

  task automatic recenter_pulse();
    RECENTER = 1'b1;
    wait_cyc(1);
    RECENTER = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    RESET_N = 1'b0; VDE = 1'b0; MODE = 1'b0; SPEED = 3'd0; AUTOFIRE = 1'b0;
    RECENTER = 1'b0; STICK_X = 8'd128; STICK_Y = 8'd128;
    TRIG_IN = 1'b0; CURSOR_IN = 1'b0; TURBO_IN = 1'b0; PAUSE_IN = 1'b0;
    wait_cyc(3);
    check("reset_JOY_X", int'(JOY_X), 128);
    check("reset_JOY_Y", int'(JOY_Y), 128);
    check("reset_FCTP_TICK", int'({F, C, T, P, FRAME_TICK}), 0);
    RESET_N = 1'b1;
    wait_cyc(2);

    // Absolute aim, then a deflection inside the deadzone.
    STICK_X = 8'd200; STICK_Y = 8'd5;
    frame(8'd200, 8'd5);
    STICK_X = 8'd135;
    frame(8'd128, 8'd5);

    // Relative aim from centre: e=88, gain 4 -> +352 per frame.
    MODE = 1'b1;
    wait_cyc(2);
    recenter_pulse();
    check("recenter_JOY_Y", int'(JOY_Y), 128);
    STICK_X = 8'd228; STICK_Y = 8'd128; SPEED = 3'd2;
    frame(8'h81, 8'd128);
    frame(8'h82, 8'd128);
    frame(8'h84, 8'd128);

    // Mode round trip reloads ACC=0x8400; +224 must give 0x84E0, not 0x8500.
    MODE = 1'b0;
    wait_cyc(2);
    check("mode_hold_JOY_X", int'(JOY_X), 'h84);
    MODE = 1'b1;
    wait_cyc(2);
    STICK_X = 8'd196;
    frame(8'h84, 8'd128);

    // Switch to absolute with stick centred: JOY waits for the tick.
    STICK_X = 8'd128;
    MODE = 1'b0;
    wait_cyc(3);
    check("mode_switch_JOY_X", int'(JOY_X), 'h84);
    frame(8'd128, 8'd128);
    MODE = 1'b1;
    wait_cyc(2);
    STICK_X = 8'd228;
    frame(8'h81, 8'd128);

    // Recentre coincident with a tick drops that frame's increment.
    STICK_X = 8'd255; STICK_Y = 8'd0;
    RECENTER = 1'b1;
    frame(8'd128, 8'd128);
    RECENTER = 1'b0;
    STICK_X = 8'd228; STICK_Y = 8'd128;
    frame(8'h81, 8'd128);

    // Negative saturation: -464 per frame from 0x8000, clamps at 0.
    recenter_pulse();
    STICK_X = 8'd0;
    for (int k = 1; k <= 200; k++) begin
      int a;
      a = 32768 - 464 * k;
      if (a < 0) a = 0;
      frame(8'(a >> 8), 8'd128);
    end

    // Positive saturation: +14720 per frame from 0, clamps at 0xFFFF.
    STICK_X = 8'd255; SPEED = 3'd7;
    frame(8'h39, 8'd128);
    frame(8'h73, 8'd128);
    frame(8'hAC, 8'd128);
    frame(8'hE6, 8'd128);
    frame(8'hFF, 8'd128);
    frame(8'hFF, 8'd128);

    // Buttons with absolute, centred aim.
    STICK_X = 8'd128;
    MODE = 1'b0;
    wait_cyc(2);
    TRIG_IN = 1'b1;
    wait_cyc(N - 2);
    TRIG_IN = 1'b0;
    wait_cyc(10);
    check("glitch_F", int'(F), 0);

    AUTOFIRE = 1'b1;
    TRIG_IN = 1'b1;
    push_f(1'b1, cyc + N);
    wait_cyc(N + 5);
    for (int k = 1; k <= 15; k++) begin
      if (k % 3 == 0) push_f(((k / 3) % 2) == 0, cyc + 1);
      frame(8'd128, 8'd128);
    end
    AUTOFIRE = 1'b0;
    push_f(1'b1, cyc + 1);
    wait_cyc(3);
    TRIG_IN = 1'b0;
    push_f(1'b0, cyc + N);
    wait_cyc(N + 5);

    CURSOR_IN = 1'b1; TURBO_IN = 1'b1; PAUSE_IN = 1'b1;
    wait_cyc(N - 1);
    check("CTP_before_debounce", int'({C, T, P}), 0);
    wait_cyc(1);
    check("CTP_after_debounce", int'({C, T, P}), 7);

    // Asynchronous reset between clock edges.
    STICK_X = 8'd200; STICK_Y = 8'd5;
    frame(8'd200, 8'd5);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_JOY_X", int'(JOY_X), 128);
    check("async_JOY_Y", int'(JOY_Y), 128);
    check("async_FCTP_TICK", int'({F, C, T, P, FRAME_TICK}), 0);
    @(negedge CLK);
    CURSOR_IN = 1'b0; TURBO_IN = 1'b0; PAUSE_IN = 1'b0;
    RESET_N = 1'b1;
    wait_cyc(2);
    STICK_X = 8'd60; STICK_Y = 8'd250;
    frame(8'd60, 8'd250);

    wait_cyc(5);
    check("aim_queue_drained", aim_q.size(), 0);
    check("f_queue_drained", fev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
